period_sequencer: RTL and testbench
===================================

Name: period_sequencer

Overview:
Generates the one-cycle period-change pulses (prelimSig, gameSig, answerSig, postSig) that drive the period-display latch. The sequence is PRELIM -> GAME -> ANSWER -> POST. Each period runs for a fixed number of seconds, counted by an internal 1 s prescaler off Clk100M. It also exposes the seconds remaining so the display path can show a countdown.

Parameters:
TICK_DIV, 100000000, Clk100M cycles per second tick; reduced in simulation.
PRELIM_SEC, 3, prelim period length in seconds; legal range 1..255.
GAME_SEC, 30, game period length in seconds; legal range 1..255.
ANSWER_SEC, 10, answer period length in seconds; legal range 1..255.
POST_SEC, 5, post period length in seconds; legal range 1..255.

Ports:
Clk100M  in  1  system clock, 100 MHz.
Reset  in  1  synchronous, active-high reset.
startBtn  in  1  debounced start level; only a rising edge acts.
answerDone  in  1  one-cycle pulse: player has submitted an answer.
prelimSig  out  1  one-cycle pulse on entry to PRELIM.
gameSig  out  1  one-cycle pulse on entry to GAME.
answerSig  out  1  one-cycle pulse on entry to ANSWER.
postSig  out  1  one-cycle pulse on entry to POST.
tick1s  out  1  one-cycle pulse on each second boundary inside a timed period.
secondsLeft  out  8  seconds remaining in the current period; 0 in IDLE.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, PRELIM, GAME, ANSWER, POST. All outputs are registered.
- Reset (sampled at the clock edge, takes priority over everything):
  - state goes to IDLE; all pulses, tick1s, busy and secondsLeft go to 0; prescaler goes to 0.
  - startPrev goes to 1, so a start button already held at reset release must be released and pressed again before it acts.
- Start edge: startBtn=1 and startPrev=0. startPrev samples startBtn every cycle.
- Entering a period (the same edge that changes state):
  - The matching *Sig pulse is high for exactly the first cycle of the new state.
  - secondsLeft loads the period's _SEC value. Prescaler clears to 0.
  - At most one *Sig is high in any cycle.
- Timed states:
  - The prescaler increments every cycle.
  - When prescaler == TICK_DIV-1: prescaler wraps to 0, secondsLeft decrements, and tick1s is high for the following cycle.
  - If secondsLeft == 1 when the tick occurs, the state advances instead of decrementing.
- Period timing: from a *Sig pulse at cycle P, the next *Sig pulse occurs at P + SEC*TICK_DIV.
- Transitions:
  - IDLE: on start edge -> PRELIM.
  - PRELIM: on timeout -> GAME.
  - GAME: on timeout -> ANSWER.
  - ANSWER: on answerDone or timeout -> POST. answerDone in the same cycle as a timeout gives a single postSig pulse, not two.
  - POST: on timeout -> IDLE, with no pulse; secondsLeft goes to 0 and busy goes low. On start edge -> PRELIM; a start edge wins over a POST timeout in the same cycle.
- Ignored inputs:
  - Start edges in PRELIM, GAME and ANSWER are ignored.
  - answerDone outside ANSWER is ignored.
- Reset mid-period: the next cycle is IDLE with all outputs 0; no pulse is emitted.
- Widths: prescaler is clog2(TICK_DIV) bits; secondsLeft is 8 bits and never wraps below 0.

Test Plan:
All scenarios use TICK_DIV=4, PRELIM_SEC=2, GAME_SEC=3, ANSWER_SEC=2, POST_SEC=2.
1. Full cycle: release Reset, pulse startBtn at cycle 10 -> prelimSig@11, gameSig@19, answerSig@31, then postSig@39. secondsLeft=0 and busy=0 from cycle 47.
2. Countdown: in GAME, tick1s pulses every 4 cycles. secondsLeft reads 3,2,1 with each value held 4 cycles, then answerSig fires.
3. Early answer: answerDone pulsed 2 cycles after answerSig -> postSig on the next cycle with secondsLeft=2. No further answerSig and no second postSig.
4. Start in POST on the exact timeout cycle -> prelimSig asserts, busy stays 1, and the IDLE state is never entered. A start pulse during GAME -> no effect.
5. Reset mid-GAME with secondsLeft=2 -> next cycle all outputs are 0. If startBtn is held through reset, no prelimSig fires until it is released and pressed again.
6. Exclusivity checker across a full random run: at most one *Sig is high per cycle, and each *Sig is exactly 1 cycle wide.

Source files
------------

// File: rtl/period_sequencer.sv
// Period sequencer: walks PRELIM -> GAME -> ANSWER -> POST on a start edge,
// emitting one-cycle entry pulses and a per-second countdown off a 1 s prescaler.
module period_sequencer #(
  parameter int TICK_DIV   = 100000000,
  parameter int PRELIM_SEC = 3,
  parameter int GAME_SEC   = 30,
  parameter int ANSWER_SEC = 10,
  parameter int POST_SEC   = 5
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       startBtn,
  input  logic       answerDone,
  output logic       prelimSig,
  output logic       gameSig,
  output logic       answerSig,
  output logic       postSig,
  output logic       tick1s,
  output logic [7:0] secondsLeft,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] PRELIM_LOAD = 8'(PRELIM_SEC);
  localparam logic [7:0] GAME_LOAD   = 8'(GAME_SEC);
  localparam logic [7:0] ANSWER_LOAD = 8'(ANSWER_SEC);
  localparam logic [7:0] POST_LOAD   = 8'(POST_SEC);

  typedef enum logic [2:0] {IDLE, PRELIM, GAME, ANSWER, POST} state_t;

  state_t state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [7:0] secs_next;
  logic prelim_next, game_next, answer_next, post_next, tick_next, busy_next;
  logic start_prev, start_edge, tick, last_sec;

  assign start_edge = startBtn & ~start_prev;
  assign tick       = (state != IDLE) && (presc == TICK_LAST);
  assign last_sec   = (secondsLeft == 8'd1);

  // A timeout is the tick that lands while one second remains; it replaces the decrement.
  always_comb begin
    state_next  = state;
    presc_next  = (state == IDLE || tick) ? '0 : presc + 1'b1;
    secs_next   = secondsLeft;
    prelim_next = 1'b0;
    game_next   = 1'b0;
    answer_next = 1'b0;
    post_next   = 1'b0;
    tick_next   = tick;
    if (tick && !last_sec && secondsLeft != 8'd0)
      secs_next = secondsLeft - 8'd1;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_next  = PRELIM;
          prelim_next = 1'b1;
          secs_next   = PRELIM_LOAD;
          presc_next  = '0;
        end
      end
      PRELIM: begin
        if (tick && last_sec) begin
          state_next = GAME;
          game_next  = 1'b1;
          secs_next  = GAME_LOAD;
          presc_next = '0;
        end
      end
      GAME: begin
        if (tick && last_sec) begin
          state_next  = ANSWER;
          answer_next = 1'b1;
          secs_next   = ANSWER_LOAD;
          presc_next  = '0;
        end
      end
      ANSWER: begin
        if (answerDone || (tick && last_sec)) begin
          state_next = POST;
          post_next  = 1'b1;
          secs_next  = POST_LOAD;
          presc_next = '0;
        end
      end
      POST: begin
        // A restart beats the POST timeout so the game loops without visiting IDLE.
        if (start_edge) begin
          state_next  = PRELIM;
          prelim_next = 1'b1;
          secs_next   = PRELIM_LOAD;
          presc_next  = '0;
        end else if (tick && last_sec) begin
          state_next = IDLE;
          secs_next  = 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        secs_next  = 8'd0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // Holding start_prev high through reset forces a fresh press after reset release.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state       <= IDLE;
      presc       <= '0;
      secondsLeft <= 8'd0;
      prelimSig   <= 1'b0;
      gameSig     <= 1'b0;
      answerSig   <= 1'b0;
      postSig     <= 1'b0;
      tick1s      <= 1'b0;
      busy        <= 1'b0;
      start_prev  <= 1'b1;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      secondsLeft <= secs_next;
      prelimSig   <= prelim_next;
      gameSig     <= game_next;
      answerSig   <= answer_next;
      postSig     <= post_next;
      tick1s      <= tick_next;
      busy        <= busy_next;
      start_prev  <= startBtn;
    end
  end

endmodule

// File: tb/tb_period_sequencer.sv
// Bench for period_sequencer: an elapsed-cycles model checked every cycle,
// directed scenarios pinned with literal cycle numbers, then a random run.
module tb_period_sequencer;

  localparam int TD = 4;
  localparam int PS = 2;
  localparam int GS = 3;
  localparam int AS = 2;
  localparam int PO = 2;
  localparam int HIST = 8192;

  logic Clk100M = 1'b0;
  logic Reset, startBtn, answerDone;
  logic prelimSig, gameSig, answerSig, postSig, tick1s, busy;
  logic [7:0] secondsLeft;

  period_sequencer #(
    .TICK_DIV(TD), .PRELIM_SEC(PS), .GAME_SEC(GS), .ANSWER_SEC(AS), .POST_SEC(PO)
  ) dut (
    .Clk100M(Clk100M), .Reset(Reset), .startBtn(startBtn), .answerDone(answerDone),
    .prelimSig(prelimSig), .gameSig(gameSig), .answerSig(answerSig), .postSig(postSig),
    .tick1s(tick1s), .secondsLeft(secondsLeft), .busy(busy)
  );

  always #5 Clk100M = ~Clk100M;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge Clk100M) cyc <= cyc + 1;

  int m_per = 0;
  int m_el = 0;
  logic m_sp = 1'b1;
  bit model_on = 0;
  logic e_prelim = 0, e_game = 0, e_answer = 0, e_post = 0, e_tick = 0, e_busy = 0;
  logic [7:0] e_secs = 0;

  logic [3:0] sig_hist [HIST];
  logic [7:0] secs_hist [HIST];
  logic busy_hist [HIST];
  logic tick_hist [HIST];
  int last_prelim = -1, last_game = -1, last_answer = -1, last_post = -1, busy_fall = -1;
  int n_answer = 0, n_post = 0;
  logic [3:0] prev_sigs = 4'd0;
  logic prev_busy = 1'b0;

  function automatic int period_sec(input int p);
    case (p)
      1: return PS;
      2: return GS;
      3: return AS;
      4: return PO;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic a);
    Reset = r;
    startBtn = s;
    answerDone = a;
  endtask

  task automatic untilCycle(input int t);
    while (cyc < t) begin
      @(posedge Clk100M);
      #1;
    end
  endtask

  // Model: period index 0..4 (0 = idle) plus cycles elapsed since entering it.
  always @(posedge Clk100M) begin : model
    int nxt;
    bit se, timeout, entered;
    if (Reset) begin
      m_per = 0; m_el = 0; m_sp = 1'b1; model_on = 1;
      e_prelim = 0; e_game = 0; e_answer = 0; e_post = 0; e_tick = 0; e_busy = 0; e_secs = 0;
    end else begin
      se = startBtn && !m_sp;
      m_sp = startBtn;
      timeout = (m_per != 0) && (m_el + 1 == period_sec(m_per) * TD);
      e_tick = (m_per != 0) && ((m_el + 1) % TD == 0);
      nxt = m_per;
      entered = 0;
      if ((m_per == 0 || m_per == 4) && se) begin
        nxt = 1; entered = 1;
      end else if (timeout) begin
        nxt = (m_per == 4) ? 0 : m_per + 1;
        entered = (nxt != 0);
      end else if (m_per == 3 && answerDone) begin
        nxt = 4; entered = 1;
      end
      if (entered || nxt == 0) m_el = 0;
      else m_el = m_el + 1;
      m_per = nxt;
      e_prelim = entered && nxt == 1;
      e_game   = entered && nxt == 2;
      e_answer = entered && nxt == 3;
      e_post   = entered && nxt == 4;
      e_busy   = (nxt != 0);
      e_secs   = (nxt == 0) ? 8'd0 : 8'(period_sec(nxt) - m_el / TD);
    end
  end

  always @(negedge Clk100M) begin
    logic [3:0] sigs;
    if (model_on) begin
      sigs = {prelimSig, gameSig, answerSig, postSig};
      checkOutput("prelimSig", 32'(prelimSig), 32'(e_prelim));
      checkOutput("gameSig", 32'(gameSig), 32'(e_game));
      checkOutput("answerSig", 32'(answerSig), 32'(e_answer));
      checkOutput("postSig", 32'(postSig), 32'(e_post));
      checkOutput("tick1s", 32'(tick1s), 32'(e_tick));
      checkOutput("secondsLeft", 32'(secondsLeft), 32'(e_secs));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("sig_exclusive", 32'($countones(sigs) <= 1), 32'd1);
      checkOutput("sig_width", 32'(sigs & prev_sigs), 32'd0);
      prev_sigs = sigs;
      if (cyc < HIST) begin
        sig_hist[cyc] = sigs;
        secs_hist[cyc] = secondsLeft;
        busy_hist[cyc] = busy;
        tick_hist[cyc] = tick1s;
      end
      if (prelimSig === 1'b1) last_prelim = cyc;
      if (gameSig === 1'b1) last_game = cyc;
      if (answerSig === 1'b1) begin last_answer = cyc; n_answer++; end
      if (postSig === 1'b1) begin last_post = cyc; n_post++; end
      if (busy === 1'b0 && prev_busy === 1'b1) busy_fall = cyc;
      prev_busy = busy;
    end
  end

  initial begin
    int base, s, na, np;
    logic st;
    applyStimulus(1'b1, 1'b0, 1'b0);
    untilCycle(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    base = cyc;

    // Full cycle and GAME countdown
    untilCycle(base + 10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(base + 11);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(base + 50);
    checkOutput("s1_prelim_cycle", 32'(last_prelim - base), 32'd11);
    checkOutput("s1_game_cycle", 32'(last_game - base), 32'd19);
    checkOutput("s1_answer_cycle", 32'(last_answer - base), 32'd31);
    checkOutput("s1_post_cycle", 32'(last_post - base), 32'd39);
    checkOutput("s1_idle_cycle", 32'(busy_fall - base), 32'd47);
    checkOutput("s1_secs_idle", 32'(secs_hist[base + 47]), 32'd0);
    checkOutput("s2_secs_g0", 32'(secs_hist[base + 19]), 32'd3);
    checkOutput("s2_secs_g3", 32'(secs_hist[base + 22]), 32'd3);
    checkOutput("s2_secs_g4", 32'(secs_hist[base + 23]), 32'd2);
    checkOutput("s2_secs_g8", 32'(secs_hist[base + 27]), 32'd1);
    checkOutput("s2_secs_g11", 32'(secs_hist[base + 30]), 32'd1);
    checkOutput("s2_tick_g4", 32'(tick_hist[base + 23]), 32'd1);
    checkOutput("s2_tick_g3", 32'(tick_hist[base + 22]), 32'd0);
    checkOutput("s2_tick_g8", 32'(tick_hist[base + 27]), 32'd1);

    // Early answer
    s = cyc;
    na = n_answer; np = n_post;
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 23);
    applyStimulus(1'b0, 1'b0, 1'b1);
    untilCycle(s + 24);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 40);
    checkOutput("s3_answer_cycle", 32'(last_answer - s), 32'd21);
    checkOutput("s3_post_cycle", 32'(last_post - s), 32'd24);
    checkOutput("s3_post_secs", 32'(secs_hist[s + 24]), 32'd2);
    checkOutput("s3_answer_count", 32'(n_answer - na), 32'd1);
    checkOutput("s3_post_count", 32'(n_post - np), 32'd1);
    checkOutput("s3_idle_cycle", 32'(busy_fall - s), 32'd32);

    // Start ignored in GAME; start on the exact POST timeout restarts without IDLE
    s = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 12);
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 13);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 36);
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 37);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 40);
    checkOutput("s4_game_cycle", 32'(last_game - s), 32'd9);
    checkOutput("s4_answer_cycle", 32'(last_answer - s), 32'd21);
    checkOutput("s4_post_cycle", 32'(last_post - s), 32'd29);
    checkOutput("s4_restart_cycle", 32'(last_prelim - s), 32'd37);
    checkOutput("s4_busy_restart", 32'(busy_hist[s + 37]), 32'd1);
    checkOutput("s4_no_idle", 32'(busy_fall < s), 32'd1);
    untilCycle(s + 80);
    checkOutput("s4_final_idle", 32'(busy_fall - s), 32'd73);

    // Reset mid-GAME with start held through reset
    s = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 14);
    applyStimulus(1'b1, 1'b1, 1'b0);
    untilCycle(s + 16);
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 25);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 26);
    applyStimulus(1'b0, 1'b1, 1'b0);
    untilCycle(s + 27);
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(s + 30);
    checkOutput("s5_secs_before", 32'(secs_hist[s + 14]), 32'd2);
    checkOutput("s5_secs_reset", 32'(secs_hist[s + 15]), 32'd0);
    checkOutput("s5_busy_reset", 32'(busy_hist[s + 15]), 32'd0);
    checkOutput("s5_sigs_reset", 32'(sig_hist[s + 15]), 32'd0);
    checkOutput("s5_held_start", 32'(busy_hist[s + 25]), 32'd0);
    checkOutput("s5_prelim_cycle", 32'(last_prelim - s), 32'd27);
    untilCycle(s + 70);

    // Random run against the model
    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) st = ~st;
      applyStimulus($urandom_range(0, 499) < 2, st, $urandom_range(0, 7) == 0);
      untilCycle(cyc + 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    untilCycle(cyc + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
